// File: rtl/wb_arbiter.sv
// Write-back arbiter: the pipeline has priority for the register-file write port; auxiliary results
// queue in a kill-tagged FIFO. Optional FIFO bypass when idle is enabled by WB_ARB_BYPASS_EN.
module wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 64,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned ADDR_W    = $clog2(NUM_REGS),
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_we,
    input  logic [ADDR_W-1:0]     pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_wd,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    input  logic [ADDR_W-1:0]     aux_rd,
    input  logic [DATA_WIDTH-1:0] aux_wd,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic [CNT_W-1:0]      aux_count
);

    logic [ADDR_W-1:0]     rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] wd_q   [DEPTH];
    logic [DEPTH-1:0]      kill_q;
    logic [PTR_W-1:0]      rptr_q, wptr_q;

    logic pipe_live, aux_fire, fifo_empty, push, pop, bypass;

    always_comb begin
        aux_ready  = (aux_count < CNT_W'(DEPTH));
        pipe_live  = pipe_we && (pipe_rd != '0);
        aux_fire   = aux_valid && aux_ready;
        fifo_empty = (aux_count == '0);
`ifdef WB_ARB_BYPASS_EN
        bypass     = aux_fire && (aux_rd != '0) && fifo_empty && !pipe_live;
`else
        bypass     = 1'b0;
`endif
        // rd==0 results are accepted but discarded here
        push       = aux_fire && (aux_rd != '0) && !bypass;
        pop        = !pipe_live && !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_a3     <= '0;
            rf_wd     <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            aux_count <= '0;
            kill_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                wd_q[i] <= '0;
            end
        end else begin
            if (pipe_live) begin
                rf_we <= 1'b1;
                rf_a3 <= pipe_rd;
                rf_wd <= pipe_wd;
            end else if (pop) begin
                rf_we <= !kill_q[rptr_q];
                rf_a3 <= rd_q[rptr_q];
                rf_wd <= wd_q[rptr_q];
            end else if (bypass) begin
                rf_we <= 1'b1;
                rf_a3 <= aux_rd;
                rf_wd <= aux_wd;
            end else begin
                rf_we <= 1'b0;
            end

            // A newer pipeline write overtakes every queued write to the same register
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_live && (rd_q[i] == pipe_rd)) kill_q[i] <= 1'b1;
            end

            // Same-cycle aux result is older than the pipeline write, so it is born killed
            if (push) begin
                rd_q[wptr_q]   <= aux_rd;
                wd_q[wptr_q]   <= aux_wd;
                kill_q[wptr_q] <= pipe_live && (aux_rd == pipe_rd);
                wptr_q         <= wptr_q + PTR_W'(1);
            end

            if (pop) rptr_q <= rptr_q + PTR_W'(1);

            aux_count <= aux_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [5:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        aux_valid;
    logic        aux_ready;
    logic [5:0]  aux_rd;
    logic [31:0] aux_wd;
    logic        rf_we;
    logic [5:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [2:0]  aux_count;

    int tests  = 0;
    int failed = 0;

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_wd   (pipe_wd),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_rd    (aux_rd),
        .aux_wd    (aux_wd),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .aux_count (aux_count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we   = 1'b0;
        pipe_rd   = '0;
        pipe_wd   = '0;
        aux_valid = 1'b0;
        aux_rd    = '0;
        aux_wd    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL reset_we got %b want 0", rf_we); end
        tests++; if (rf_a3 !== 6'd0) begin failed++; $display("FAIL reset_a3 got %0d want 0", rf_a3); end
        tests++; if (rf_wd !== 32'd0) begin failed++; $display("FAIL reset_wd got %h want 0", rf_wd); end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL reset_count got %0d want 0", aux_count); end
        tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b want 1", aux_ready); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_pipe_latency();
        pipe_we = 1'b1; pipe_rd = 6'd5; pipe_wd = 32'hDEADBEEF;
        cycle();
        pipe_we = 1'b0;
        tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
            failed++; $display("FAIL pipe_write got we=%b a3=%0d wd=%h want 1/5/deadbeef", rf_we, rf_a3, rf_wd);
        end
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL pipe_after got we=%b want 0", rf_we); end
    endtask

    task automatic test_aux_latency();
        tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL aux_ready_idle got %b want 1", aux_ready); end
        aux_valid = 1'b1; aux_rd = 6'd7; aux_wd = 32'h11;
        cycle();
        aux_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'd7, 32'h11}) begin
            failed++; $display("FAIL aux_bypass got we=%b a3=%0d wd=%h want 1/7/11", rf_we, rf_a3, rf_wd);
        end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL aux_bypass_count got %0d want 0", aux_count); end
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL aux_bypass_after got we=%b want 0", rf_we); end
`else
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL aux_lat1 got we=%b want 0", rf_we); end
        tests++; if (aux_count !== 3'd1) begin failed++; $display("FAIL aux_lat1_count got %0d want 1", aux_count); end
        cycle();
        tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'd7, 32'h11}) begin
            failed++; $display("FAIL aux_lat2 got we=%b a3=%0d wd=%h want 1/7/11", rf_we, rf_a3, rf_wd);
        end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL aux_lat2_count got %0d want 0", aux_count); end
`endif
        cycle();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_rd = 6'(10 + i); pipe_wd = 32'(32'hA0 + i);
            aux_valid = 1'b1; aux_rd = 6'(20 + i); aux_wd = 32'(32'h100 + i);
            cycle();
            tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'(10 + i), 32'(32'hA0 + i)}) begin
                failed++; $display("FAIL fill_pipe%0d got we=%b a3=%0d wd=%h", i, rf_we, rf_a3, rf_wd);
            end
        end
        tests++; if (aux_count !== 3'd4) begin failed++; $display("FAIL fill_count got %0d want 4", aux_count); end
        tests++; if (aux_ready !== 1'b0) begin failed++; $display("FAIL fill_ready got %b want 0", aux_ready); end
        // Offer while full: must not be accepted
        pipe_we = 1'b1; pipe_rd = 6'd14; pipe_wd = 32'hA4;
        aux_valid = 1'b1; aux_rd = 6'd30; aux_wd = 32'h999;
        cycle();
        tests++; if (aux_count !== 3'd4) begin failed++; $display("FAIL full_hold got %0d want 4", aux_count); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'(20 + i), 32'(32'h100 + i)}) begin
                failed++; $display("FAIL drain%0d got we=%b a3=%0d wd=%h", i, rf_we, rf_a3, rf_wd);
            end
            tests++; if (aux_count !== 3'(3 - i)) begin
                failed++; $display("FAIL drain_count%0d got %0d want %0d", i, aux_count, 3 - i);
            end
            tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL drain_ready%0d got %b want 1", i, aux_ready); end
        end
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL drain_end got we=%b a3=%0d want 0", rf_we, rf_a3); end
    endtask

    task automatic test_kill();
        pipe_we = 1'b1; pipe_rd = 6'd12; pipe_wd = 32'h12;
        aux_valid = 1'b1; aux_rd = 6'd9; aux_wd = 32'hAA;
        cycle();
        tests++; if (aux_count !== 3'd1) begin failed++; $display("FAIL kill_queued got %0d want 1", aux_count); end
        aux_valid = 1'b0; pipe_rd = 6'd9; pipe_wd = 32'hBB;
        cycle();
        pipe_we = 1'b0;
        tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'd9, 32'hBB}) begin
            failed++; $display("FAIL kill_pipe got we=%b a3=%0d wd=%h want 1/9/bb", rf_we, rf_a3, rf_wd);
        end
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL kill_slot got we=%b wd=%h want 0", rf_we, rf_wd); end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL kill_count got %0d want 0", aux_count); end
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL kill_after got we=%b wd=%h want 0", rf_we, rf_wd); end
    endtask

    task automatic test_same_cycle_and_r0();
        pipe_we = 1'b1; pipe_rd = 6'd3; pipe_wd = 32'h44;
        aux_valid = 1'b1; aux_rd = 6'd3; aux_wd = 32'h33;
        cycle();
        tests++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 6'd3, 32'h44}) begin
            failed++; $display("FAIL same_pipe got we=%b a3=%0d wd=%h want 1/3/44", rf_we, rf_a3, rf_wd);
        end
        tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL same_ready got %b want 1", aux_ready); end
        pipe_rd = 6'd0; pipe_wd = 32'h55;
        aux_rd = 6'd0; aux_wd = 32'h66;
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL r0_slot got we=%b wd=%h want 0", rf_we, rf_wd); end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL r0_count got %0d want 0", aux_count); end
        tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL r0_ready got %b want 1", aux_ready); end
        idle_inputs();
        cycle();
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL r0_after got we=%b wd=%h want 0", rf_we, rf_wd); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_rd = 6'(40 + i); pipe_wd = 32'(i);
            aux_valid = 1'b1; aux_rd = 6'(50 + i); aux_wd = 32'(32'h500 + i);
            cycle();
        end
        idle_inputs();
        cycle();
        tests++; if ({rf_we, rf_a3, aux_count} !== {1'b1, 6'd50, 3'd3}) begin
            failed++; $display("FAIL mid_first got we=%b a3=%0d cnt=%0d want 1/50/3", rf_we, rf_a3, aux_count);
        end
        rst_n = 1'b0;
        #1;
        tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL mid_rst_we got %b want 0", rf_we); end
        tests++; if (aux_count !== 3'd0) begin failed++; $display("FAIL mid_rst_count got %0d want 0", aux_count); end
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++; if (rf_we !== 1'b0) begin failed++; $display("FAIL mid_post%0d got we=%b a3=%0d want 0", i, rf_we, rf_a3); end
        end
        tests++; if (aux_ready !== 1'b1) begin failed++; $display("FAIL mid_ready got %b want 1", aux_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_pipe_latency();
        test_aux_latency();
        test_fill_drain();
        test_kill();
        test_same_cycle_and_r0();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
